conv2d_window_gen: RTL

//  Producer side of the 3x3 convolution window interface: turns a raster pixel stream into one 3x3 window per output pixel.
//  Two line buffers plus a 3x3 shift window; window row r / col c = image rows cr-1..cr+1 / cols cc-1..cc+1 around centre (cr,cc).

---
 rtl/conv2d_pkg.sv | 33 +++
 rtl/conv2d_window_gen_if.sv | 24 ++
 rtl/conv2d_line_buffer.sv | 39 +++
 rtl/conv2d_window_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and configuration for the 3x3 convolution window generator.
// Optional feature macro: CONV2D_ZERO_PAD_EN ("same" padding with phantom
// positions). When undefined the block performs "valid" convolution.
package conv2d_pkg;

  localparam int FILT_DIM  = 3;
  localparam int BIT_WIDTH = 16;

`ifdef CONV2D_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  // Window element [0][0] is the top-left tap.
  typedef logic signed [BIT_WIDTH-1:0] window_t [FILT_DIM-1:0][FILT_DIM-1:0];

  typedef enum logic {
    ST_STREAM,  // scan row is inside the image
    ST_DRAIN    // phantom bottom row, padding only
  } scan_state_e;

  // Last scan index along one dimension (one extra phantom index when padding).
  function automatic int scan_max(input int dim);
    return ZERO_PAD ? dim : dim - 1;
  endfunction

  // Smallest scan index at which a window is complete enough to emit.
  function automatic int emit_min();
    return ZERO_PAD ? 1 : 2;
  endfunction

endpackage

// File: rtl/conv2d_window_gen_if.sv
// Pixel-in / window-out stream bundle of the window generator.
// master: the window generator itself; slave: its upstream/downstream side.
interface conv2d_window_gen_if import conv2d_pkg::*; #(
  parameter int bitWidth = 16
);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [bitWidth-1:0] in_pixel;
  logic                       out_valid;
  logic                       out_last;
  logic signed [bitWidth-1:0] out_window [FILT_DIM-1:0][FILT_DIM-1:0];

  modport master (
    input  in_valid, in_pixel,
    output in_ready, out_valid, out_last, out_window
  );

  modport slave (
    output in_valid, in_pixel,
    input  in_ready, out_valid, out_last, out_window
  );

endinterface

// File: rtl/conv2d_line_buffer.sv
// Circular line buffer: on every advance the oldest entry is read out and
// replaced by the incoming pixel, giving a delay of exactly DEPTH advances.
module conv2d_line_buffer #(
  parameter int bitWidth = 16,
  parameter int DEPTH    = 29
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       advance,
  input  logic signed [bitWidth-1:0] din,
  output logic signed [bitWidth-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic signed [bitWidth-1:0] mem [DEPTH];
  logic [PTR_W-1:0]           ptr;

  assign dout = mem[ptr];

  // Read/write pointer wraps at DEPTH-1.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Storage write; stale contents are hidden by the window masking.
  always_ff @(posedge clock) begin
    // NOTE: storage arrays are not reset; a reset here would turn the RAM into a flop bank.
    if (advance) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/conv2d_window_gen.sv
// 3x3 window generator: raster pixel stream in, one registered 3x3 window
// per output pixel out. Build macro CONV2D_ZERO_PAD_EN selects "same"
// padding; otherwise "valid" convolution.
module conv2d_window_gen import conv2d_pkg::*; #(
  parameter int bitWidth = 16,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28
) (
  input  logic                clock,
  input  logic                reset,
  conv2d_window_gen_if.master bus
);

  localparam int SR_MAX   = scan_max(IMG_H);
  localparam int SC_MAX   = scan_max(IMG_W);
  localparam int SR_W     = $clog2(IMG_H + 1);
  localparam int SC_W     = $clog2(IMG_W + 1);
  localparam int EMIT_MIN = emit_min();

  typedef logic signed [bitWidth-1:0] pix_t;
  typedef pix_t win_t [FILT_DIM-1:0][FILT_DIM-1:0];

  logic [SR_W-1:0] sr, sr_nxt;
  logic [SC_W-1:0] sc, sc_nxt;
  scan_state_e     state;
  logic            is_real, advance, emit, at_last, mask_top, mask_left;
  pix_t            push_pix, lb0_out, lb1_out;
  win_t            win_q, win_nxt, win_out, out_q;
  logic            out_valid_q, out_last_q;

  // Scan position register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= '0;
      sc <= '0;
    end else begin
      sr <= sr_nxt;
      sc <= sc_nxt;
    end
  end

  // Scan state decode, real/phantom handshake and next scan position.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state  = ST_STREAM;
    sr_nxt = sr;
    sc_nxt = sc;
    if (sr >= SR_W'(IMG_H)) state = ST_DRAIN;
    is_real     = (state == ST_STREAM) && (sc < SC_W'(IMG_W));
    bus.in_ready = is_real && !reset;
    advance     = !reset && (!is_real || bus.in_valid);
    if (advance) begin
      if (sc == SC_W'(SC_MAX)) begin
        sc_nxt = '0;
        sr_nxt = (sr == SR_W'(SR_MAX)) ? '0 : sr + 1'b1;
      end else begin
        sc_nxt = sc + 1'b1;
      end
    end
  end

  // Row above (lb0) and two rows above (lb1) the pushed pixel.
  conv2d_line_buffer #(.bitWidth(bitWidth), .DEPTH(SC_MAX + 1)) u_lb0 (
    .clock(clock), .reset(reset), .advance(advance), .din(push_pix), .dout(lb0_out)
  );

  conv2d_line_buffer #(.bitWidth(bitWidth), .DEPTH(SC_MAX + 1)) u_lb1 (
    .clock(clock), .reset(reset), .advance(advance), .din(lb0_out), .dout(lb1_out)
  );

  // Shifted window including this step's column, emission decode and masking.
  always_comb begin
    push_pix  = is_real ? bus.in_pixel : '0;
    emit      = (sr >= SR_W'(EMIT_MIN)) && (sc >= SC_W'(EMIT_MIN));
    at_last   = (sr == SR_W'(SR_MAX)) && (sc == SC_W'(SC_MAX));
    // Centre (sr-1, sc-1): top row / left column fall outside the image at index 1.
    mask_top  = ZERO_PAD && (sr == SR_W'(1));
    mask_left = ZERO_PAD && (sc == SC_W'(1));
    for (int r = 0; r < FILT_DIM; r++) begin
      for (int c = 0; c < FILT_DIM - 1; c++) begin
        win_nxt[r][c] = win_q[r][c+1];
      end
    end
    win_nxt[0][FILT_DIM-1] = lb1_out;
    win_nxt[1][FILT_DIM-1] = lb0_out;
    win_nxt[2][FILT_DIM-1] = push_pix;
    for (int r = 0; r < FILT_DIM; r++) begin
      for (int c = 0; c < FILT_DIM; c++) begin
        win_out[r][c] = ((mask_top && r == 0) || (mask_left && c == 0)) ? '0 : win_nxt[r][c];
      end
    end
  end

  // 3x3 shift window; unreset because masking hides anything stale.
  always_ff @(posedge clock) begin
    if (advance) begin
      win_q <= win_nxt;
    end
  end

  // Registered outputs, one cycle after the advancing step.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '{default: '0};
    end else begin
      out_valid_q <= advance && emit;
      out_last_q  <= advance && emit && at_last;
      if (advance && emit) begin
        out_q <= win_out;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_window = out_q;

endmodule
